// File: rtl/seq_cascade_compare.sv
// seq_cascade_compare: nibble-serial WIDTH-bit magnitude comparator on the 4-bit cascade protocol; SEQ_CASCADE_COMPARE_SIGNED_EN selects two's-complement operands.
module seq_cascade_compare #(
  parameter int WIDTH = 16,
  localparam int NIBBLES = WIDTH / 4
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iStart,
  input  logic [WIDTH-1:0] iData_a,
  input  logic [WIDTH-1:0] iData_b,
  input  logic [2:0]       iData,
  output logic             oBusy,
  output logic             oDone,
  output logic [2:0]       oData
);
  localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state;
  logic [WIDTH-1:0] a_q, b_q;
  logic [2:0]       res, nres, norm;
  logic [IW-1:0]    idx;
  logic             last;
  logic [3:0]       an, bn;
  // operands shift right each RUN cycle so the current nibble is always at [3:0]
  always_comb begin
    last = idx == IW'(NIBBLES - 1);
`ifdef SEQ_CASCADE_COMPARE_SIGNED_EN
    an = a_q[3:0] ^ {last, 3'b000};
    bn = b_q[3:0] ^ {last, 3'b000};
`else
    an = a_q[3:0];
    bn = b_q[3:0];
`endif
    nres = an > bn ? 3'b100 : an < bn ? 3'b010 : res;
    norm = (iData == 3'b100 || iData == 3'b010 || iData == 3'b001) ? iData : 3'b001;
  end
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state <= IDLE;
      oBusy <= 1'b0;
      oDone <= 1'b0;
      oData <= 3'b000;
      idx   <= '0;
      res   <= 3'b001;
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      oDone <= 1'b0;
      case (state)
        IDLE: if (iStart) begin
          a_q   <= iData_a;
          b_q   <= iData_b;
          res   <= norm;
          idx   <= '0;
          state <= RUN;
          oBusy <= 1'b1;
        end
        RUN: begin
          res <= nres;
          a_q <= a_q >> 4;
          b_q <= b_q >> 4;
          if (last) begin
            state <= DONE;
            oData <= nres;
            oDone <= 1'b1;
          end else idx <= idx + 1'b1;
        end
        DONE: begin
          state <= IDLE;
          oBusy <= 1'b0;
        end
        default: begin
          state <= IDLE;
          oBusy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seq_cascade_compare.sv
// tb_seq_cascade_compare: directed scoreboard bench for seq_cascade_compare at WIDTH=16.
module tb_seq_cascade_compare;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [15:0] da = '0, db = '0;
  logic [2:0]  di = '0;
  logic        busy, done;
  logic [2:0]  dout;
  logic [2:0]  exp_q[$];
  logic [2:0]  last_res = 3'b000;
  int          checks = 0, errors = 0;

  seq_cascade_compare #(.WIDTH(16)) dut (
    .iClk(clk), .iRst(rst), .iStart(start), .iData_a(da), .iData_b(db),
    .iData(di), .oBusy(busy), .oDone(done), .oData(dout)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] model(input logic [15:0] a, input logic [15:0] b, input logic [2:0] c);
    logic [2:0] n;
    n = (c == 3'b100 || c == 3'b010 || c == 3'b001) ? c : 3'b001;
`ifdef SEQ_CASCADE_COMPARE_SIGNED_EN
    if ($signed(a) > $signed(b)) return 3'b100;
    if ($signed(a) < $signed(b)) return 3'b010;
`else
    if (a > b) return 3'b100;
    if (a < b) return 3'b010;
`endif
    return n;
  endfunction

  task automatic pop_chk(input string tag);
    logic [2:0] r;
    if (exp_q.size() == 0) begin
      chk({tag, " sb_empty"}, 16'd0, 16'd1);
    end else begin
      r = exp_q.pop_front();
      chk({tag, " data"}, 16'(dout), 16'(r));
      last_res = r;
    end
  endtask

  // called just after the start edge; returns the cycle count at which oDone was seen
  task automatic wait_done(input string tag, output int n);
    n = 1;
    while (!done && n < 20) begin
      chk({tag, " busy"}, 16'(busy), 16'd1);
      tick;
      n++;
    end
    chk({tag, " done"}, 16'(done), 16'd1);
    chk({tag, " busy_done"}, 16'(busy), 16'd1);
    pop_chk(tag);
  endtask

  task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic [2:0] c);
    da = a; db = b; di = c; start = 1'b1;
    tick;
    start = 1'b0;
    exp_q.push_back(model(a, b, c));
  endtask

  task automatic run(input logic [15:0] a, input logic [15:0] b, input logic [2:0] c, input string tag);
    int n;
    launch(a, b, c);
    chk({tag, " hold"}, 16'(dout), 16'(last_res));
    wait_done(tag, n);
    chk({tag, " lat"}, 16'(n), 16'd5);
    tick;
    chk({tag, " idle"}, {14'd0, busy, done}, 16'd0);
  endtask

  initial begin
    int n, k;
    int seen[$];
    tick; tick;
    rst = 1'b0;
    chk("reset", {11'd0, busy, done, dout}, 16'd0);

    run(16'h1234, 16'h1234, 3'b001, "eq");
    run(16'h1230, 16'h1231, 3'b001, "low_lt");
    run(16'h5678, 16'h4FFF, 3'b001, "top_gt");
    run(16'h8000, 16'h7FFF, 3'b001, "sign");
    run(16'hABCD, 16'hABCD, 3'b100, "pass_gt");
    run(16'hABCD, 16'hABCD, 3'b010, "pass_lt");
    run(16'hABCD, 16'hABCD, 3'b011, "norm_011");
    run(16'hABCD, 16'hABCD, 3'b000, "norm_000");
    run(16'hFFFF, 16'h0000, 3'b010, "ffff");
    run(16'h0001, 16'h0000, 3'b010, "lsb");

    // continuous start: accepted every 6 cycles
    da = 16'h1230; db = 16'h1231; di = 3'b001; start = 1'b1;
    repeat (3) exp_q.push_back(model(da, db, di));
    tick;
    for (int c = 1; c <= 17; c++) begin
      if (c > 1) tick;
      if (done) begin
        seen.push_back(c);
        pop_chk("held");
      end
    end
    start = 1'b0;
    tick;
    chk("held count", 16'(seen.size()), 16'd3);
    for (int i = 0; i < seen.size() && i < 3; i++) chk("held cycle", 16'(seen[i]), 16'(5 + 6 * i));
    chk("held idle", 16'(busy), 16'd0);

    // start during RUN with new operands is ignored
    launch(16'h5678, 16'h4FFF, 3'b001);
    tick;
    da = 16'h0000; db = 16'hFFFF; di = 3'b010; start = 1'b1;
    tick;
    start = 1'b0;
    wait_done("run_start", n);
    k = 0;
    for (int c = 0; c < 8; c++) begin
      tick;
      if (done) k++;
    end
    chk("run_start extra", 16'(k), 16'd0);

    // start in the DONE cycle dropped, next cycle accepted
    launch(16'h1234, 16'h1234, 3'b100);
    wait_done("done_drop", n);
    da = 16'h0001; db = 16'h0002; di = 3'b001; start = 1'b1;
    tick;
    chk("done_drop idle", 16'(busy), 16'd0);
    tick;
    start = 1'b0;
    exp_q.push_back(model(16'h0001, 16'h0002, 3'b001));
    chk("after_done busy", 16'(busy), 16'd1);
    wait_done("after_done", n);
    chk("after_done lat", 16'(n), 16'd5);
    tick;

    // reset in the second RUN cycle, with a simultaneous start request
    da = 16'hFFFF; db = 16'h0000; di = 3'b001; start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    rst = 1'b1; start = 1'b1;
    tick;
    rst = 1'b0; start = 1'b0;
    chk("mid_rst", {11'd0, busy, done, dout}, 16'd0);
    last_res = 3'b000;
    k = 0;
    for (int c = 0; c < 8; c++) begin
      tick;
      if (done || busy) k++;
    end
    chk("mid_rst quiet", 16'(k), 16'd0);
    run(16'h0001, 16'h0002, 3'b001, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
